// File: rtl/alu_control_unit_if.sv
// Memory, ALU and register-file bus of the sequencer.
// master = alu_control_unit, slave = the memory/ALU/register-file environment.
interface alu_control_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic [3:0]  rf_raddr1;
  logic [3:0]  rf_raddr2;
  logic [15:0] rf_rdata1;
  logic [15:0] rf_rdata2;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output alu_opcode,
    input  alu_result, alu_zero,
    output rf_raddr1, rf_raddr2,
    input  rf_rdata1, rf_rdata2,
    output rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  alu_opcode,
    output alu_result, alu_zero,
    input  rf_raddr1, rf_raddr2,
    output rf_rdata1, rf_rdata2,
    input  rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/alu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit Von Neumann core.
// Owns PC, IR and the zero flag; all bus outputs are decoded from those registers.
module alu_control_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_control_unit_if.master  bus,
  output logic [15:0]         pc,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic        r_zflag;

  logic [3:0]  w_op;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs1;
  logic [3:0]  w_rs2;
  logic        w_isAlu;
  logic        w_isLoad;
  logic        w_isStore;
  logic        w_isJz;
  logic        w_isHalt;
  logic        w_irValid;

  assign w_op      = r_ir[15:12];
  assign w_rd      = r_ir[11:8];
  assign w_rs1     = r_ir[7:4];
  assign w_rs2     = r_ir[3:0];
  assign w_isAlu   = (w_op >= 4'd1) && (w_op <= 4'd6);
  assign w_isLoad  = (w_op == 4'd7);
  assign w_isStore = (w_op == 4'd8);
  assign w_isJz    = (w_op == 4'd9);
  assign w_isHalt  = (w_op == 4'hF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
      r_zflag <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.mem_ack) begin
            r_ir    <= bus.mem_rdata;
            r_pc    <= r_pc + 16'd1;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: r_state <= S_EXECUTE;
        S_EXECUTE: begin
          if (w_isAlu) begin
            r_zflag <= bus.alu_zero;
            r_state <= S_FETCH;
          end else if (w_isLoad || w_isStore) begin
            r_state <= S_MEM;
          end else if (w_isJz) begin
            if (r_zflag) begin
              r_pc <= bus.rf_rdata1;
            end
            r_state <= S_FETCH;
          end else if (w_isHalt) begin
            r_state <= S_HALT;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            r_state <= S_FETCH;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held so nothing leaks out of the reset cycle.
  assign w_irValid = rst_n && ((r_state == S_DECODE) || (r_state == S_EXECUTE) || (r_state == S_MEM));

  assign bus.rf_raddr1  = w_irValid ? w_rs1 : 4'h0;
  assign bus.rf_raddr2  = w_irValid ? w_rs2 : 4'h0;
  assign bus.alu_opcode = w_irValid ? w_op  : 4'h0;
  assign halted         = rst_n && (r_state == S_HALT);
  assign pc             = r_pc;

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 16'h0000;
    if (rst_n) begin
      if (r_state == S_FETCH) begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = r_pc;
      end else if (r_state == S_MEM) begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = w_isStore;
        bus.mem_addr  = bus.rf_rdata1;
        bus.mem_wdata = w_isStore ? bus.rf_rdata2 : 16'h0000;
      end
    end
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = 4'h0;
    bus.rf_wdata = 16'h0000;
    if (rst_n) begin
      if ((r_state == S_EXECUTE) && w_isAlu) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = w_rd;
        bus.rf_wdata = bus.alu_result;
      end else if ((r_state == S_MEM) && w_isLoad && bus.mem_ack) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = w_rd;
        bus.rf_wdata = bus.mem_rdata;
      end
    end
  end

endmodule

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 16-bit Von Neumann core.
- Holds the PC, instruction register (IR) and zero flag.
- Drives the ALU opcode, register-file read/write ports and a single shared instruction/data memory port through a req/ack handshake.
- Sits between the memory, the register file and the 4-bit-opcode ALU (ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOT=6).

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- mem_req  output  1  memory request, held until ack.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  16  memory address.
- mem_wdata  output  16  store data.
- mem_rdata  input  16  read data, valid in the cycle mem_ack=1.
- mem_ack  input  1  one-cycle completion pulse.
- alu_opcode  output  4  opcode to the ALU.
- alu_result  input  16  ALU result (combinational).
- alu_zero  input  1  ALU zero flag (combinational).
- rf_raddr1  output  4  register-file read address 1 (rs1).
- rf_raddr2  output  4  register-file read address 2 (rs2).
- rf_rdata1  input  16  R[rs1] (combinational read).
- rf_rdata2  input  16  R[rs2].
- rf_we  output  1  register write enable.
- rf_waddr  output  4  write address (rd).
- rf_wdata  output  16  write data.
- pc  output  16  current PC.
- halted  output  1  1 in HALT state.

Behaviour:
- Reset (rst_n=0 at posedge):
  - Registers: state=FETCH, pc=RESET_PC, IR=0, zflag=0.
  - Outputs in the following cycle, before any fetch request takes effect: mem_req=0, mem_we=0, rf_we=0, halted=0, all buses 0.
  - Reset applies mid-transaction too. Any outstanding access is abandoned; a late mem_ack is ignored.
- Instruction format: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2.
  - op 1..6: ALU operations.
  - op 7 LOAD: rd <= mem[R[rs1]].
  - op 8 STORE: mem[R[rs1]] <= R[rs2].
  - op 9 JZ: if zflag then pc <= R[rs1].
  - op 0 and 0xA..0xE: NOP.
  - op 0xF: HALT.
- All outputs are decoded from state/IR/pc registers. mem_* and rf_* are 0 whenever not listed as asserted below.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ack: IR<=mem_rdata, pc<=pc+1 (wraps FFFF->0000), go to DECODE.
  - Without ack: stay in FETCH, outputs unchanged.
- DECODE (1 cycle):
  - rf_raddr1=IR[7:4], rf_raddr2=IR[3:0], alu_opcode=IR[15:12].
  - Go to EXECUTE.
- Read addresses and alu_opcode hold those IR-derived values in DECODE, EXECUTE and MEM. In FETCH and HALT they are 0.
- EXECUTE (1 cycle):
  - ALU op: rf_we=1, rf_waddr=rd, rf_wdata=alu_result; zflag<=alu_zero; go to FETCH.
  - LOAD/STORE: go to MEM.
  - JZ: if zflag, pc<=rf_rdata1; go to FETCH. zflag is unchanged.
  - NOP: go to FETCH.
  - HALT: go to HALT.
- MEM:
  - mem_req=1, mem_addr=rf_rdata1, mem_we=(op==8), mem_wdata=rf_rdata2 (0 for LOAD).
  - On mem_ack: for LOAD, rf_we=1, rf_waddr=rd, rf_wdata=mem_rdata in that same cycle. Go to FETCH.
  - mem_req drops in the cycle after the ack.
- HALT:
  - halted=1, no requests; mem_ack ignored.
  - Exit only via reset.
- zflag is updated only by ALU ops; LOAD/STORE/NOP/JZ leave it unchanged.
- mem_ack while mem_req=0 is ignored.
- Latency with zero-wait memory (ack in first request cycle):
  - ALU op, NOP, JZ: 3 cycles.
  - LOAD/STORE: 4 cycles.
  - Each extra wait cycle adds 1.
- Exactly one mem_req transaction per FETCH/MEM visit. Address/we/wdata are stable from request to ack.

Test Plan:
- Reset then zero-wait memory with mem[0]=16'h1312, R1=5, R2=7 (ALU model) -> alu_opcode=1 in DECODE/EXECUTE; rf_we=1 with rf_waddr=3, rf_wdata=12 exactly in cycle 3; pc=1.
- mem[0]=16'h2412, R1=R2=9, then mem[1]=16'h9050, R5=16'h0040 -> zflag set by SUB, JZ takes pc=16'h0040. Repeat with R2=8: pc=2.
- LOAD 16'h7630 with R3=16'h0100, mem[0x100]=16'hBEEF, ack after 3 wait cycles -> mem_addr=16'h0100 and mem_we=0 held through the waits; rf_we=1, rf_waddr=6, rf_wdata=16'hBEEF in the ack cycle.
- STORE 16'h8012, R1=16'h0020, R2=16'h55AA -> mem_we=1, mem_addr=16'h0020, mem_wdata=16'h55AA until ack; no rf_we.
- HALT 16'hF000 at pc=RESET_PC -> halted=1 from cycle 4; no further mem_req even with spurious mem_ack. rst_n=0 -> pc=RESET_PC, halted=0.
- Reset asserted during FETCH wait (mem_ack never sent), then ack pulsed in the reset cycle -> ack ignored; after release, fetch restarts at RESET_PC; pc=FFFF fetch wraps pc to 0000.
